// File: rtl/a2_bridge_pkg.sv
// rtl/a2_bridge_pkg.sv - bridge select codes, control-byte bit layout and reset defaults
package a2_bridge_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_CONTROL = 2'd0;
  localparam sel_t SEL_DATA    = 2'd1;
  localparam sel_t SEL_ADDR_LO = 2'd2;
  localparam sel_t SEL_ADDR_HI = 2'd3;

  localparam int CTRL_RW_N  = 0;
  localparam int CTRL_IRQ_N = 2;

  localparam logic [7:0] CONTROL_RESET_DEFAULT = 8'hFF;

  // true for the two selects that read back the captured Apple address
  function automatic logic is_addr_sel(input sel_t sel);
    return (sel == SEL_ADDR_LO) || (sel == SEL_ADDR_HI);
  endfunction

endpackage

// File: rtl/a2_bridge_sync.sv
// rtl/a2_bridge_sync.sv - N-stage synchronizer with rise/fall pulses of the synchronized value
module a2_bridge_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  // fewer than two flops is not a synchronizer, so clamp the depth
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [WIDTH-1:0] r_stage [N];
  logic [WIDTH-1:0] r_prev;

  // shift the asynchronous input down the chain and remember the last synchronized value
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N; i++) r_stage[i] <= '0;
      r_prev <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
      r_prev <= r_stage[N-1];
    end
  end

  assign o_q    = r_stage[N-1];
  assign o_rise = r_stage[N-1] & ~r_prev;
  assign o_fall = ~r_stage[N-1] & r_prev;

endmodule

// File: rtl/a2_bridge_responder.sv
// rtl/a2_bridge_responder.sv - bus-side bridge responder; A2_BRIDGE_PROTOCOL_CHECK_EN adds protocol error reporting
module a2_bridge_responder
  import a2_bridge_pkg::*;
#(
  parameter int         SYNC_STAGES         = 2,
  parameter logic [7:0] CONTROL_RESET       = CONTROL_RESET_DEFAULT,
  parameter int         BUS_DATA_OUT_ENABLE = 1
) (
  input  logic        clk_logic,
  input  logic        device_reset,
  input  logic [1:0]  sel_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [7:0]  d_i,
  output logic [7:0]  d_o,
  output logic        d_oe_o,
  input  logic        bus_d_oe_i,
  input  logic        a2_phi0_i,
  input  logic [15:0] a2_addr_i,
  input  logic        a2_rw_n_i,
  input  logic [7:0]  a2_data_i,
  output logic [7:0]  a2_data_o,
  output logic        a2_data_oe_o,
  input  logic [6:0]  gpio_i,
  output logic [7:0]  control_o,
  output logic        irq_n_o
`ifdef A2_BRIDGE_PROTOCOL_CHECK_EN
  ,
  output logic        proto_err_o,
  output logic [7:0]  proto_err_count_o
`endif
);

  localparam logic OE_ALLOWED = (BUS_DATA_OUT_ENABLE != 0);

  logic        w_phi0_sync;
  logic        w_phi0_rise;
  logic        w_phi0_fall;
  logic [6:0]  w_gpio_sync;
  logic [6:0]  w_unused_gpio_rise;
  logic [6:0]  w_unused_gpio_fall;
  logic        w_wr_edge;
  logic        w_addr_guard;
  logic [7:0]  w_ctrl_byte;
  logic [7:0]  w_d_o;

  logic [15:0] r_addr;
  logic        r_rw_n;
  logic [15:0] r_shadow_addr;
  logic        r_shadow_rw_n;
  logic        r_pending;
  logic [7:0]  r_data_snap;
  logic [7:0]  r_data_out;
  logic [7:0]  r_control;
  logic        r_wr_q;
  logic        r_a2_oe;

  a2_bridge_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_phi0_sync (
    .i_clk  (clk_logic),
    .i_rst  (device_reset),
    .i_d    (a2_phi0_i),
    .o_q    (w_phi0_sync),
    .o_rise (w_phi0_rise),
    .o_fall (w_phi0_fall)
  );

  a2_bridge_sync #(.WIDTH(7), .STAGES(SYNC_STAGES)) u_gpio_sync (
    .i_clk  (clk_logic),
    .i_rst  (device_reset),
    .i_d    (gpio_i),
    .o_q    (w_gpio_sync),
    .o_rise (w_unused_gpio_rise),
    .o_fall (w_unused_gpio_fall)
  );

  assign w_wr_edge    = wr_i & ~r_wr_q;
  // the master is mid-way through reading an address byte pair; a new address must not tear it
  assign w_addr_guard = rd_i & is_addr_sel(sel_i);

  // address/rw capture on phi0 rise, parked in the shadow while an address read is in flight
  always_ff @(posedge clk_logic or posedge device_reset) begin
    if (device_reset) begin
      r_addr        <= '0;
      r_rw_n        <= 1'b1;
      r_shadow_addr <= '0;
      r_shadow_rw_n <= 1'b1;
      r_pending     <= 1'b0;
    end else if (w_phi0_rise) begin
      if (w_addr_guard) begin
        r_shadow_addr <= a2_addr_i;
        r_shadow_rw_n <= a2_rw_n_i;
        r_pending     <= 1'b1;
      end else begin
        r_addr    <= a2_addr_i;
        r_rw_n    <= a2_rw_n_i;
        r_pending <= 1'b0;
      end
    end else if (r_pending && !w_addr_guard) begin
      r_addr    <= r_shadow_addr;
      r_rw_n    <= r_shadow_rw_n;
      r_pending <= 1'b0;
    end
  end

  // data capture on phi0 fall; when we drive the Apple bus, record what we drove
  always_ff @(posedge clk_logic or posedge device_reset) begin
    if (device_reset) begin
      r_data_snap <= '0;
    end else if (w_phi0_fall) begin
      r_data_snap <= r_a2_oe ? r_data_out : a2_data_i;
    end
  end

  // bridge writes: a single register update per wr_i rising edge
  always_ff @(posedge clk_logic or posedge device_reset) begin
    if (device_reset) begin
      r_wr_q     <= 1'b0;
      r_control  <= CONTROL_RESET;
      r_data_out <= '0;
    end else begin
      r_wr_q <= wr_i;
      if (w_wr_edge) begin
        case (sel_i)
          SEL_CONTROL: r_control  <= d_i;
          SEL_DATA:    r_data_out <= d_i;
          default:     ;
        endcase
      end
    end
  end

  // Apple data bus drive enable follows the master's request only while phi0 is high
  always_ff @(posedge clk_logic or posedge device_reset) begin
    if (device_reset) begin
      r_a2_oe <= 1'b0;
    end else begin
      r_a2_oe <= bus_d_oe_i & OE_ALLOWED & w_phi0_sync;
    end
  end

  // control byte: synchronized control lines above the captured rw_n
  always_comb begin
    w_ctrl_byte            = {w_gpio_sync, 1'b0};
    w_ctrl_byte[CTRL_RW_N] = r_rw_n;
  end

  // read mux is purely combinational so d_o follows sel_i within the cycle
  always_comb begin
    w_d_o = '0;
    case (sel_i)
      SEL_CONTROL: w_d_o = w_ctrl_byte;
      SEL_DATA:    w_d_o = r_data_snap;
      SEL_ADDR_LO: w_d_o = r_addr[7:0];
      SEL_ADDR_HI: w_d_o = r_addr[15:8];
      default:     w_d_o = '0;
    endcase
  end

  assign d_o          = w_d_o;
  assign d_oe_o       = rd_i & ~wr_i & ~device_reset;
  assign a2_data_o    = r_data_out;
  assign a2_data_oe_o = r_a2_oe;
  assign control_o    = r_control;
  assign irq_n_o      = r_control[CTRL_IRQ_N];

`ifdef A2_BRIDGE_PROTOCOL_CHECK_EN
  logic [1:0] r_sel_q;
  logic       r_proto_err;
  logic [7:0] r_err_count;
  logic       w_ev_rdwr;
  logic       w_ev_selchg;
  logic       w_ev_badwr;
  logic [1:0] w_ev_num;
  logic [8:0] w_count_sum;

  assign w_ev_rdwr   = rd_i & wr_i;
  assign w_ev_selchg = wr_i & r_wr_q & (sel_i != r_sel_q);
  assign w_ev_badwr  = w_wr_edge & is_addr_sel(sel_i);
  assign w_ev_num    = {1'b0, w_ev_rdwr} + {1'b0, w_ev_selchg} + {1'b0, w_ev_badwr};
  assign w_count_sum = {1'b0, r_err_count} + {7'b0, w_ev_num};

  // sticky error flag and saturating count of protocol violations, one step per event
  always_ff @(posedge clk_logic or posedge device_reset) begin
    if (device_reset) begin
      r_sel_q     <= '0;
      r_proto_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_sel_q <= sel_i;
      if (w_ev_num != 2'd0) begin
        r_proto_err <= 1'b1;
        r_err_count <= w_count_sum[8] ? 8'hFF : w_count_sum[7:0];
      end
    end
  end

  assign proto_err_o       = r_proto_err;
  assign proto_err_count_o = r_err_count;
`endif

endmodule

// File: tb/tb_a2_bridge_responder.sv
// tb/tb_a2_bridge_responder.sv - self-checking bench for a2_bridge_responder
module tb_a2_bridge_responder;
  import a2_bridge_pkg::*;

  localparam int SYNC = 2;

  logic        clk;
  logic        device_reset;
  logic [1:0]  sel_i;
  logic        rd_i;
  logic        wr_i;
  logic [7:0]  d_i;
  logic [7:0]  d_o;
  logic        d_oe_o;
  logic        bus_d_oe_i;
  logic        a2_phi0_i;
  logic [15:0] a2_addr_i;
  logic        a2_rw_n_i;
  logic [7:0]  a2_data_i;
  logic [7:0]  a2_data_o;
  logic        a2_data_oe_o;
  logic [6:0]  gpio_i;
  logic [7:0]  control_o;
  logic        irq_n_o;
`ifdef A2_BRIDGE_PROTOCOL_CHECK_EN
  logic        proto_err_o;
  logic [7:0]  proto_err_count_o;
`endif

  a2_bridge_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk_logic    (clk),
    .device_reset (device_reset),
    .sel_i        (sel_i),
    .rd_i         (rd_i),
    .wr_i         (wr_i),
    .d_i          (d_i),
    .d_o          (d_o),
    .d_oe_o       (d_oe_o),
    .bus_d_oe_i   (bus_d_oe_i),
    .a2_phi0_i    (a2_phi0_i),
    .a2_addr_i    (a2_addr_i),
    .a2_rw_n_i    (a2_rw_n_i),
    .a2_data_i    (a2_data_i),
    .a2_data_o    (a2_data_o),
    .a2_data_oe_o (a2_data_oe_o),
    .gpio_i       (gpio_i),
    .control_o    (control_o),
    .irq_n_o      (irq_n_o)
`ifdef A2_BRIDGE_PROTOCOL_CHECK_EN
    ,
    .proto_err_o       (proto_err_o),
    .proto_err_count_o (proto_err_count_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  // transaction-level model of the bridge-visible state
  logic [7:0]  m_control;
  logic [7:0]  m_data_out;
  logic [15:0] m_addr;
  logic        m_rw;
  logic        m_pend;
  logic [15:0] m_pend_addr;
  logic        m_pend_rw;
  logic [7:0]  m_snap;
  logic        m_oe;
  logic        m_phi0;
  int          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_control = 8'hFF; m_data_out = 8'h00; m_addr = 16'h0000; m_rw = 1'b1;
    m_pend = 1'b0; m_pend_addr = 16'h0; m_pend_rw = 1'b1; m_snap = 8'h00;
    m_oe = 1'b0; m_err = 0;
  endtask

  function automatic logic [7:0] exp_d_o();
    case (sel_i)
      2'd0:    return {gpio_i, m_rw};
      2'd1:    return m_snap;
      2'd2:    return m_addr[7:0];
      default: return m_addr[15:8];
    endcase
  endfunction

  // continuous comparison against the model while outputs are settled
  always @(negedge clk) begin
    if (chk_en) begin
      chk("d_o", {24'b0, d_o}, {24'b0, exp_d_o()});
      chk("d_oe_o", {31'b0, d_oe_o}, {31'b0, rd_i & ~wr_i});
      chk("control_o", {24'b0, control_o}, {24'b0, m_control});
      chk("irq_n_o", {31'b0, irq_n_o}, {31'b0, m_control[2]});
      chk("a2_data_o", {24'b0, a2_data_o}, {24'b0, m_data_out});
      chk("a2_data_oe_o", {31'b0, a2_data_oe_o}, {31'b0, m_oe});
`ifdef A2_BRIDGE_PROTOCOL_CHECK_EN
      chk("proto_err_count_o", {24'b0, proto_err_count_o}, m_err);
      chk("proto_err_o", {31'b0, proto_err_o}, {31'b0, m_err != 0});
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // a parked address becomes visible once the master stops reading address bytes
  task automatic model_tick();
    if (m_pend && !(rd_i && sel_i >= 2'd2)) begin
      m_addr = m_pend_addr; m_rw = m_pend_rw; m_pend = 1'b0;
    end
  endtask

  task automatic set_bus(input logic rd, input logic [1:0] sel);
    rd_i = rd; sel_i = sel;
    cyc();
    model_tick();
  endtask

  task automatic set_bus_oe(input logic v);
    bus_d_oe_i = v;
    cyc();
    m_oe = v & m_phi0;
  endtask

  task automatic bus_write(input logic [1:0] sel, input logic [7:0] data, input int hold, input logic rd);
    rd_i = rd; sel_i = sel; d_i = data; wr_i = 1'b1;
    for (int k = 0; k < hold; k++) begin
      cyc();
      if (k == 0) begin
        if (sel == SEL_CONTROL) m_control = data;
        if (sel == SEL_DATA)    m_data_out = data;
        if (sel >= 2'd2)        m_err++;
      end
      if (rd) m_err++;
      model_tick();
      d_i = ~data;
    end
    wr_i = 1'b0; rd_i = 1'b0;
    cyc();
    model_tick();
  endtask

  task automatic phi0_rise(input logic [15:0] addr, input logic rw);
    chk_en = 1'b0;
    a2_addr_i = addr; a2_rw_n_i = rw; a2_phi0_i = 1'b1;
    repeat (SYNC + 2) cyc();
    if (rd_i && sel_i >= 2'd2) begin
      m_pend = 1'b1; m_pend_addr = addr; m_pend_rw = rw;
    end else begin
      m_addr = addr; m_rw = rw; m_pend = 1'b0;
    end
    m_phi0 = 1'b1;
    m_oe = bus_d_oe_i;
    chk_en = 1'b1;
  endtask

  task automatic phi0_fall(input logic [7:0] data);
    chk_en = 1'b0;
    a2_data_i = data; a2_phi0_i = 1'b0;
    repeat (SYNC + 2) cyc();
    m_snap = m_oe ? m_data_out : data;
    m_oe = 1'b0; m_phi0 = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    device_reset = 1'b1; sel_i = 2'd0; rd_i = 1'b0; wr_i = 1'b0; d_i = 8'h00;
    bus_d_oe_i = 1'b0; a2_phi0_i = 1'b0; a2_addr_i = 16'h0; a2_rw_n_i = 1'b1;
    a2_data_i = 8'h00; gpio_i = 7'h7F; m_phi0 = 1'b0;
    model_reset();
    repeat (3) cyc();
    device_reset = 1'b0;
    repeat (SYNC + 2) cyc();

    // reset state read through the control select
    rd_i = 1'b1; sel_i = SEL_CONTROL;
    cyc();
    chk_en = 1'b1;
    chk("reset d_o", {24'b0, d_o}, 32'hFF);
    chk("reset control_o", {24'b0, control_o}, 32'hFF);
    chk("reset irq_n_o", {31'b0, irq_n_o}, 32'h1);
    chk("reset a2_data_oe_o", {31'b0, a2_data_oe_o}, 32'h0);
    chk("reset d_oe_o", {31'b0, d_oe_o}, 32'h1);

    // address capture and byte-wise readback
    rd_i = 1'b0;
    phi0_rise(16'hC0E8, 1'b0);
    set_bus(1'b1, SEL_ADDR_LO);
    chk("addr lo C0E8", {24'b0, d_o}, 32'hE8);
    set_bus(1'b1, SEL_ADDR_HI);
    chk("addr hi C0E8", {24'b0, d_o}, 32'hC0);
    set_bus(1'b1, SEL_CONTROL);
    chk("ctrl rw_n=0", {24'b0, d_o}, 32'hFE);
    phi0_fall(8'h96);
    set_bus(1'b1, SEL_DATA);
    chk("data snap 96", {24'b0, d_o}, 32'h96);

    // torn-address guard
    set_bus(1'b1, SEL_ADDR_LO);
    phi0_rise(16'h1234, 1'b1);
    chk("guard lo old", {24'b0, d_o}, 32'hE8);
    set_bus(1'b1, SEL_ADDR_HI);
    chk("guard hi old", {24'b0, d_o}, 32'hC0);
    set_bus(1'b1, SEL_CONTROL);
    chk("commit rw_n=1", {24'b0, d_o}, 32'hFF);
    set_bus(1'b0, SEL_ADDR_HI);
    chk("commit hi 12", {24'b0, d_o}, 32'h12);
    set_bus(1'b0, SEL_ADDR_LO);
    chk("commit lo 34", {24'b0, d_o}, 32'h34);

    // different control-line pattern
    chk_en = 1'b0;
    gpio_i = 7'h2A;
    repeat (SYNC + 1) cyc();
    chk_en = 1'b1;
    set_bus(1'b1, SEL_CONTROL);
    chk("gpio 2A", {24'b0, d_o}, 32'h55);
    phi0_fall(8'h11);

    // held write produces exactly one update
    set_bus(1'b0, SEL_CONTROL);
    bus_write(SEL_CONTROL, 8'hFB, 3, 1'b0);
    chk("held write control", {24'b0, control_o}, 32'hFB);
    chk("held write irq_n", {31'b0, irq_n_o}, 32'h0);
`ifdef A2_BRIDGE_PROTOCOL_CHECK_EN
    chk("held write errcount", {24'b0, proto_err_count_o}, 32'h0);
`endif

    // data-out drive and self-capture on phi0 fall
    bus_write(SEL_DATA, 8'hA5, 1, 1'b0);
    chk("a2_data_o A5", {24'b0, a2_data_o}, 32'hA5);
    phi0_rise(16'h0300, 1'b1);
    chk("oe before request", {31'b0, a2_data_oe_o}, 32'h0);
    set_bus_oe(1'b1);
    chk("oe after request", {31'b0, a2_data_oe_o}, 32'h1);
    phi0_fall(8'h3C);
    chk("oe after fall", {31'b0, a2_data_oe_o}, 32'h0);
    set_bus(1'b1, SEL_DATA);
    chk("snap driven A5", {24'b0, d_o}, 32'hA5);

    // rd and wr together, then asynchronous reset mid-cycle
    set_bus(1'b0, SEL_DATA);
    phi0_rise(16'hBEEF, 1'b0);
    chk("oe re-driven", {31'b0, a2_data_oe_o}, 32'h1);
    bus_write(SEL_DATA, 8'h5A, 1, 1'b1);
    chk("rdwr write data", {24'b0, a2_data_o}, 32'h5A);
`ifdef A2_BRIDGE_PROTOCOL_CHECK_EN
    chk("rdwr errcount", {24'b0, proto_err_count_o}, 32'h1);
    chk("rdwr err flag", {31'b0, proto_err_o}, 32'h1);
`endif
    set_bus(1'b1, SEL_ADDR_LO);
    chk("pre-reset addr lo", {24'b0, d_o}, 32'hEF);
    @(negedge clk);
    #2;
    chk_en = 1'b0;
    device_reset = 1'b1;
    #1;
    chk("async control_o", {24'b0, control_o}, 32'hFF);
    chk("async irq_n_o", {31'b0, irq_n_o}, 32'h1);
    chk("async a2_data_oe_o", {31'b0, a2_data_oe_o}, 32'h0);
    chk("async a2_data_o", {24'b0, a2_data_o}, 32'h00);
    chk("async d_oe_o", {31'b0, d_oe_o}, 32'h0);
    chk("async addr lo", {24'b0, d_o}, 32'h00);
`ifdef A2_BRIDGE_PROTOCOL_CHECK_EN
    chk("async errcount", {24'b0, proto_err_count_o}, 32'h0);
    chk("async err flag", {31'b0, proto_err_o}, 32'h0);
`endif
    sel_i = SEL_DATA;
    #1;
    chk("async data snap", {24'b0, d_o}, 32'h00);
    model_reset();
    rd_i = 1'b0; bus_d_oe_i = 1'b0;
    repeat (2) cyc();
    device_reset = 1'b0;
    repeat (SYNC + 3) cyc();
    // phi0 was still high, so the first synchronized rise captures BEEF
    m_addr = 16'hBEEF; m_rw = 1'b0;
    chk_en = 1'b1;
    set_bus(1'b0, SEL_ADDR_HI);
    chk("post-reset addr hi", {24'b0, d_o}, 32'hBE);

    // writes to address selects are ignored
    bus_write(SEL_ADDR_LO, 8'h77, 1, 1'b0);
    chk("ignored write control", {24'b0, control_o}, 32'hFF);
    chk("ignored write data", {24'b0, a2_data_o}, 32'h00);
`ifdef A2_BRIDGE_PROTOCOL_CHECK_EN
    chk("bad sel errcount", {24'b0, proto_err_count_o}, 32'h1);
`endif
    phi0_fall(8'h42);
    set_bus(1'b1, SEL_DATA);
    chk("final snap 42", {24'b0, d_o}, 32'h42);
    cyc();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
